// File: rtl/pc_unit.sv
// Program counter with stall-held redirects and a circular
// return-address stack used to check jr targets.
module pc_unit #(
    parameter int unsigned WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned INCR = 4,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             stall,
    input  logic             branchTaken,
    input  logic [WIDTH-1:0] branchTarget,
    input  logic             jump,
    input  logic             jumpLink,
    input  logic [WIDTH-1:0] jumpTarget,
    input  logic             jumpReg,
    input  logic [WIDTH-1:0] jrTarget,
    output logic [WIDTH-1:0] pcOut,
    output logic [WIDTH-1:0] pcPlusInc,
    output logic             redirectPending,
    output logic [WIDTH-1:0] rasTop,
    output logic             rasValid,
    output logic             rasMismatch
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0] INC = WIDTH'(INCR);
    localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] ptgt;
    logic [WIDTH-1:0] tgt;
    logic             pend;
    logic             mis;
    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]    top;
    logic [PW-1:0]    top_up;
    logic [PW-1:0]    top_dn;
    logic [PW-1:0]    wr_idx;
    logic [CW-1:0]    cnt;
    logic             empty;
    logic             redir;
    logic             sel_jr;
    logic             sel_j;
    logic             sel_b;
    logic             do_push;
    logic             do_pop;
    logic             do_repl;
    logic             grow;
    logic             wr_en;

    assign pcOut           = pc;
    assign pcPlusInc       = pc + INC;
    assign redirectPending = pend;
    assign rasMismatch     = mis;
    assign empty           = (cnt == '0);
    assign rasValid        = ~empty;
    assign rasTop          = empty ? '0 : ras[top];

    assign top_up = (top == LAST) ? '0 : top + 1'b1;
    assign top_dn = (top == '0) ? LAST : top - 1'b1;

    // One-hot request select: jumpReg > jump > branchTaken
    assign sel_jr = jumpReg;
    assign sel_j  = jump & ~jumpReg;
    assign sel_b  = branchTaken & ~jump & ~jumpReg;

    always_comb begin
        redir = 1'b0;
        tgt   = '0;
        unique case (1'b1)
            sel_jr: begin
                redir = 1'b1;
                tgt   = jrTarget;
            end
            sel_j: begin
                redir = 1'b1;
                tgt   = jumpTarget;
            end
            sel_b: begin
                redir = 1'b1;
                tgt   = branchTarget;
            end
            default: ;
        endcase
    end

    assign do_push = ~stall & jump & jumpLink & ~jumpReg;
    assign do_pop  = ~stall & jumpReg & ~jumpLink;
    assign do_repl = ~stall & jumpReg & jumpLink;
    // jalr on an empty stack behaves as a push
    assign grow    = do_push | (do_repl & empty);
    assign wr_en   = grow | (do_repl & ~empty);
    assign wr_idx  = grow ? top_up : top;

    always_ff @(negedge CLK) begin
        if (RST) begin
            pc   <= RESET_VECTOR;
            pend <= 1'b0;
            ptgt <= '0;
            mis  <= 1'b0;
            top  <= LAST;
            cnt  <= '0;
        end else if (stall) begin
            if (redir) begin
                pend <= 1'b1;
                ptgt <= tgt;
            end
        end else begin
            if (redir)
                pc <= tgt;
            else if (pend)
                pc <= ptgt;
            else
                pc <= pcPlusInc;
            pend <= 1'b0;
            mis  <= sel_jr & ~empty & (jrTarget != rasTop);
            if (grow) begin
                top <= top_up;
                if (cnt != FULL)
                    cnt <= cnt + 1'b1;
            end else if (do_pop & ~empty) begin
                top <= top_dn;
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(negedge CLK) begin
        if (!RST && wr_en)
            ras[wr_idx] <= pcPlusInc;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: queue-based reference model for
// the 32-bit instance, directed expectations for an 8-bit one.
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0040_0000;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pinc;
        logic [31:0] rtop;
        logic        pend;
        logic        rv;
        logic        mis;
    } exp_t;

    logic CLK;
    logic rst, stall, br, j, jl, jr;
    logic [31:0] bt, jt, jrt;
    logic [31:0] pc, pinc, rtop;
    logic pend, rv, mis;

    logic rst8, stall8, br8, j8, jl8, jr8;
    logic [7:0] bt8, jt8, jrt8;
    logic [7:0] pc8, pinc8, rtop8;
    logic pend8, rv8, mis8;

    int total = 0;
    int bad = 0;

    exp_t q[$];
    exp_t q8[$];

    logic [31:0] m_pc, m_ptgt;
    bit m_pend, m_mis;
    logic [31:0] m_ras[$];

    pc_unit #(
        .WIDTH(32), .RESET_VECTOR(RV), .INCR(4), .RAS_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .RST(rst), .stall(stall),
        .branchTaken(br), .branchTarget(bt),
        .jump(j), .jumpLink(jl), .jumpTarget(jt),
        .jumpReg(jr), .jrTarget(jrt),
        .pcOut(pc), .pcPlusInc(pinc),
        .redirectPending(pend), .rasTop(rtop),
        .rasValid(rv), .rasMismatch(mis)
    );

    pc_unit #(
        .WIDTH(8), .RESET_VECTOR(8'hF8), .INCR(4), .RAS_DEPTH(DEPTH)
    ) dut8 (
        .CLK(CLK), .RST(rst8), .stall(stall8),
        .branchTaken(br8), .branchTarget(bt8),
        .jump(j8), .jumpLink(jl8), .jumpTarget(jt8),
        .jumpReg(jr8), .jrTarget(jrt8),
        .pcOut(pc8), .pcPlusInc(pinc8),
        .redirectPending(pend8), .rasTop(rtop8),
        .rasValid(rv8), .rasMismatch(mis8)
    );

    initial begin
        CLK = 1'b1;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    // State updates on the falling edge; sample 1 time unit later
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pcOut", pc, e.pc);
                chk("pcPlusInc", pinc, e.pinc);
                chk("rasTop", rtop, e.rtop);
                chk("redirectPending", 32'(pend), 32'(e.pend));
                chk("rasValid", 32'(rv), 32'(e.rv));
                chk("rasMismatch", 32'(mis), 32'(e.mis));
            end
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk("pcOut8", 32'(pc8), e.pc);
                chk("pcPlusInc8", 32'(pinc8), e.pinc);
                chk("rasTop8", 32'(rtop8), e.rtop);
                chk("redirectPending8", 32'(pend8), 32'(e.pend));
                chk("rasValid8", 32'(rv8), 32'(e.rv));
                chk("rasMismatch8", 32'(mis8), 32'(e.mis));
            end
        end
    end

    task automatic step(input bit r, input bit s, input bit b,
                        input logic [31:0] btv, input bit jj,
                        input bit jlk, input logic [31:0] jtv,
                        input bit jrr, input logic [31:0] jrv);
        logic [31:0] t;
        logic [31:0] ret;
        bit red;
        exp_t e;
        @(posedge CLK);
        rst = r; stall = s; br = b; bt = btv;
        j = jj; jl = jlk; jt = jtv; jr = jrr; jrt = jrv;
        if (r) begin
            m_pc = RV; m_pend = 0; m_ptgt = 0;
            m_mis = 0; m_ras.delete();
        end else begin
            red = 1;
            if (jrr) t = jrv;
            else if (jj) t = jtv;
            else if (b) t = btv;
            else begin red = 0; t = 0; end
            if (s) begin
                if (red) begin m_pend = 1; m_ptgt = t; end
            end else begin
                ret = m_pc + 32'd4;
                if (jrr) begin
                    if (m_ras.size() > 0) begin
                        m_mis = (jrv != m_ras[m_ras.size()-1]);
                        if (jlk) m_ras[m_ras.size()-1] = ret;
                        else void'(m_ras.pop_back());
                    end else begin
                        m_mis = 0;
                        if (jlk) m_ras.push_back(ret);
                    end
                end else begin
                    m_mis = 0;
                    if (jj && jlk) begin
                        m_ras.push_back(ret);
                        if (m_ras.size() > DEPTH)
                            void'(m_ras.pop_front());
                    end
                end
                m_pc = red ? t : (m_pend ? m_ptgt : m_pc + 32'd4);
                m_pend = 0;
            end
        end
        e.pc = m_pc;
        e.pinc = m_pc + 32'd4;
        e.rtop = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'd0;
        e.rv = (m_ras.size() > 0);
        e.pend = m_pend;
        e.mis = m_mis;
        q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step8(input bit r, input bit s, input bit b,
                         input logic [7:0] btv, input bit jj,
                         input bit jlk, input logic [7:0] jtv,
                         input logic [7:0] epc, input bit ep,
                         input logic [7:0] etop, input bit ev);
        logic [7:0] pi;
        exp_t e;
        @(posedge CLK);
        rst8 = r; stall8 = s; br8 = b; bt8 = btv;
        j8 = jj; jl8 = jlk; jt8 = jtv; jr8 = 0; jrt8 = 0;
        pi = epc + 8'd4;
        e.pc = 32'(epc);
        e.pinc = 32'(pi);
        e.rtop = 32'(etop);
        e.pend = ep;
        e.rv = ev;
        e.mis = 0;
        q8.push_back(e);
    endtask

    initial begin
        bit rr, ss, bb, jj, jlk, jrr;
        logic [31:0] btv, jtv, jrv;
        rst = 1; stall = 0; br = 0; j = 0; jl = 0; jr = 0;
        bt = 0; jt = 0; jrt = 0;
        rst8 = 1; stall8 = 0; br8 = 0; j8 = 0; jl8 = 0; jr8 = 0;
        bt8 = 0; jt8 = 0; jrt8 = 0;
        m_pc = RV; m_ptgt = 0; m_pend = 0; m_mis = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) idle();
        // stall capture, release with pending target
        step(0, 1, 1, 'h100, 0, 0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        // new jump on release beats pending branch
        step(0, 1, 1, 'h100, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 'h200, 0, 0);
        // priority
        step(0, 0, 1, 'h500, 1, 0, 'h400, 1, 'h300);
        // call/return, matching then mismatching
        step(0, 0, 0, 0, 1, 0, 'h40, 0, 0);
        step(0, 0, 0, 0, 1, 1, 'h80, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 'h44);
        step(0, 0, 0, 0, 1, 0, 'h40, 0, 0);
        step(0, 0, 0, 0, 1, 1, 'h80, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 'h48);
        idle();
        // overflow: 5 calls into a 4-deep stack
        step(0, 0, 0, 0, 1, 0, 'h10, 0, 0);
        for (int k = 2; k <= 6; k++)
            step(0, 0, 0, 0, 1, 1, 32'(k * 16), 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 'h54);
        step(0, 0, 0, 0, 0, 0, 0, 1, 'h44);
        step(0, 0, 0, 0, 0, 0, 0, 1, 'h34);
        step(0, 0, 0, 0, 0, 0, 0, 1, 'h24);
        step(0, 0, 0, 0, 0, 0, 0, 1, 'h99C);
        // jalr replace, then jalr on empty
        step(0, 0, 0, 0, 1, 1, 'h200, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 'h123);
        step(0, 0, 0, 0, 0, 0, 0, 1, 'h208);
        step(0, 0, 0, 0, 0, 1, 0, 1, 'h300);
        // reset while pending and RAS non-empty
        step(0, 0, 0, 0, 1, 1, 'h500, 0, 0);
        step(0, 1, 1, 'h600, 0, 0, 0, 0, 0);
        step(1, 1, 1, 'h700, 1, 1, 'h800, 0, 0);
        idle();

        for (int i = 0; i < 3000; i++) begin
            rr  = ($urandom % 200) == 0;
            ss  = ($urandom % 4) == 0;
            bb  = ($urandom % 3) == 0;
            jj  = ($urandom % 5) == 0;
            jlk = ($urandom % 2) == 0;
            jrr = ($urandom % 6) == 0;
            btv = $urandom & 32'hFFFF_FFFC;
            jtv = $urandom & 32'hFFFF_FFFC;
            jrv = $urandom & 32'hFFFF_FFFC;
            if (m_ras.size() > 0 && ($urandom % 2) == 0)
                jrv = m_ras[m_ras.size()-1];
            if (($urandom % 50) == 0)
                jtv = 32'hFFFF_FFF8;
            step(rr, ss, bb, btv, jj, jlk, jtv, jrr, jrv);
        end

        // 8-bit instance: wrap and mid-operation reset
        step8(1, 0, 0, 0, 0, 0, 0, 8'hF8, 0, 8'h00, 0);
        step8(0, 0, 0, 0, 0, 0, 0, 8'hFC, 0, 8'h00, 0);
        step8(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0);
        step8(0, 0, 0, 0, 1, 1, 8'h40, 8'h40, 0, 8'h04, 1);
        step8(0, 1, 1, 8'h80, 0, 0, 0, 8'h40, 1, 8'h04, 1);
        step8(1, 1, 1, 8'h80, 0, 0, 0, 8'hF8, 0, 8'h00, 0);
        step8(0, 0, 0, 0, 0, 0, 0, 8'hFC, 0, 8'h00, 0);

        repeat (3) @(posedge CLK);
        total++;
        if (q.size() != 0 || q8.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d left want 0",
                     q.size() + q8.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS datapath; the next generation of the plain PC register. It holds the fetch address and computes the next PC from sequential increment, branch, jump and jump-register requests. Redirects that arrive during a stall are remembered and applied when the stall releases. A small circular return-address stack (RAS) tracks `jal` return addresses so that `jr` targets can be checked.

## Interface

Parameters:

- `WIDTH`, 32, address width in bits.
- `RESET_VECTOR`, 0, value loaded into the PC on reset.
- `INCR`, 4, sequential increment.
- `RAS_DEPTH`, 4, number of RAS entries; must be ≥2.

Ports:

- `CLK`  in  1  clock; all state updates on the falling edge, matching the datapath.
- `RST`  in  1  synchronous, active-high reset, sampled on the falling edge of `CLK`.
- `stall`  in  1  hold the PC this cycle.
- `branchTaken`  in  1  conditional branch resolved taken.
- `branchTarget`  in  WIDTH  branch destination.
- `jump`  in  1  `j`/`jal` request.
- `jumpLink`  in  1  with `jump` or `jumpReg`: push the return address (`jal`/`jalr`).
- `jumpTarget`  in  WIDTH  `j`/`jal` destination.
- `jumpReg`  in  1  `jr`/`jalr` request.
- `jrTarget`  in  WIDTH  register-supplied destination.
- `pcOut`  out  WIDTH  current fetch address.
- `pcPlusInc`  out  WIDTH  `pcOut + INCR`, combinational.
- `redirectPending`  out  1  a captured redirect is waiting for the stall to release.
- `rasTop`  out  WIDTH  top RAS entry; 0 when empty.
- `rasValid`  out  1  RAS is non-empty.
- `rasMismatch`  out  1  registered; last accepted `jr` disagreed with the RAS prediction.

## Operation

- **Request priority (same cycle):** `jumpReg` > `jump` > `branchTaken`. The selected request defines the "new redirect" and its target.
- **`stall`=1:**
  - `pcOut` holds.
  - A new redirect overwrites the pending register: target is stored and `redirectPending` is set.
  - The RAS and `rasMismatch` do not change.
- **`stall`=0:** the next PC is chosen as follows.
  1. If there is a new redirect, its target is used. This discards any pending redirect.
  2. Otherwise, if a redirect is pending, the pending target is used.
  3. Otherwise, `pcOut + INCR` is used.
  - `redirectPending` clears in all three cases.
- **RAS actions (only on non-stalled edges, only for a new redirect, not a pending one):**
  - Push: `jump`&`jumpLink` and not `jumpReg`.
    - Writes `pcOut + INCR` at top+1.
    - When full, it overwrites the oldest entry (circular); the count saturates at `RAS_DEPTH`.
  - Pop: `jumpReg`&!`jumpLink`.
    - If `rasValid`: `rasMismatch` <= (`jrTarget` != `rasTop`), then the stack pops.
    - If empty: the stack does not change and `rasMismatch` <= 0.
  - Replace: `jumpReg`&`jumpLink` (`jalr`).
    - Compares and updates `rasMismatch` as for pop.
    - Then the top is overwritten with `pcOut + INCR` and the count is unchanged.
    - If the stack is empty, it pushes instead.
  - Any other non-stalled edge: `rasMismatch` <= 0.
- **Width rules:** all additions are modulo 2^WIDTH; the PC wraps from all-ones + INCR to the low address.

## Timing

- **Reset values (one falling edge with `RST`=1):**
  - `pcOut`=`RESET_VECTOR`.
  - `redirectPending`=0.
  - RAS empty, so `rasValid`=0 and `rasTop`=0.
  - `rasMismatch`=0.
- `RST` overrides `stall` and every request; a pending redirect and RAS contents are lost on mid-operation reset.
- **Latency:**
  - A non-stalled redirect is visible on `pcOut` after the next falling edge (1 cycle).
  - A pending redirect is visible 1 edge after `stall` deasserts.
- `pcPlusInc`, `rasTop` and `rasValid` are combinational from state; `rasMismatch` is valid for one cycle after the accepting edge.
- No initial-block reliance: state is defined only by `RST`.

## Test plan

- **Reset:** `RST`=1 for 1 edge with `RESET_VECTOR`=0x00400000 -> `pcOut`=0x00400000, `rasValid`=0, `redirectPending`=0. Then 3 free edges -> 0x00400004, 0x00400008, 0x0040000C.
- **Stall capture:** `stall`=1 with `branchTaken`, target 0x100, then 2 more stalled edges with no request -> `pcOut` unchanged, `redirectPending`=1. Release `stall` -> `pcOut`=0x100 and `redirectPending`=0. Repeat with a new `jump` to 0x200 on the release cycle -> `pcOut`=0x200.
- **Priority:** `jumpReg`(0x300), `jump`(0x400) and `branchTaken`(0x500) in the same unstalled cycle -> `pcOut`=0x300.
- **RAS call/return:** at `pcOut`=0x40, `jal` to 0x80 -> `rasTop`=0x44. At 0x80, `jr` 0x44 -> `pcOut`=0x44, `rasMismatch`=0, `rasValid`=0. Repeat with `jr` 0x48 -> `rasMismatch`=1.
- **RAS overflow:** `RAS_DEPTH`=4, 5 consecutive `jal` from 0x10, 0x20, 0x30, 0x40, 0x50 -> 4 pops return 0x54, 0x44, 0x34, 0x24, then `rasValid`=0. A `jr` on the empty stack -> `rasMismatch`=0 and the PC still redirects.
- **Wrap and reset mid-operation:** `WIDTH`=8, `pcOut`=0xFC, free edge -> 0x00. Assert `RST` while `redirectPending`=1 and the RAS is non-empty -> all state returns to reset values.
